// File: rtl/bimux_pkg.sv
// Shared types and constants for the bimux transfer controller.
package bimux_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TURN    = 3'd1,
    PRESENT = 3'd2,
    HOLD    = 3'd3,
    DONE    = 3'd4
  } xfer_state_t;

  localparam logic DIR_GATHER  = 1'b0;
  localparam logic DIR_SCATTER = 1'b1;

  localparam int LANES_DEF = 8;
  localparam int SEL_W_DEF = 3;

endpackage

// File: rtl/bimux_xfer_ctrl_chk.sv
// Property checker for the transfer controller: the controller must never drive
// the shared line while the mux is also driving it (mux_dir = gather).
module bimux_xfer_ctrl_chk
  import bimux_pkg::*;
(
  input logic clk,
  input logic rst_n,
  input logic line_oe,
  input logic mux_dir
);

  a_no_contention: assert property (@(posedge clk) disable iff (!rst_n)
    !(line_oe && (mux_dir == DIR_GATHER)));

endmodule

// File: rtl/bimux_xfer_ctrl.sv
// Byte scatter/gather sequencer for one bimux_8x1 with tri-state turnaround.
// Optional build macro BIMUX_XFER_MSB_FIRST_EN walks lanes from LANES-1 down to 0.
module bimux_xfer_ctrl
  import bimux_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int SEL_W  = SEL_W_DEF,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             rw,
  input  logic [LANES-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [LANES-1:0] rdata,
  output logic             mux_dir,
  output logic [SEL_W-1:0] mux_sel,
  inout  wire              mux_line
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
`ifdef BIMUX_XFER_MSB_FIRST_EN
  localparam logic [SEL_W-1:0] FIRST_LANE = SEL_W'(LANES - 1);
  localparam logic [SEL_W-1:0] LAST_LANE  = SEL_W'(0);
`else
  localparam logic [SEL_W-1:0] FIRST_LANE = SEL_W'(0);
  localparam logic [SEL_W-1:0] LAST_LANE  = SEL_W'(LANES - 1);
`endif

  xfer_state_t      state_r, state_s;
  logic             rw_r, rw_s;
  logic [LANES-1:0] wdata_r, wdata_s;
  logic [LANES-1:0] rdata_q_r, rdata_q_s;
  logic [LANES-1:0] rdata_r, rdata_s;
  logic [SEL_W-1:0] lane_r, lane_s;
  logic [CNT_W-1:0] settle_r, settle_s;
  logic             mux_dir_r, mux_dir_s;
  logic             line_oe_r, line_oe_s;
  logic             line_val_r, line_val_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;

  // Next-state, lane walk and registered-output values.
  always_comb begin
    state_s    = state_r;
    rw_s       = rw_r;
    wdata_s    = wdata_r;
    rdata_q_s  = rdata_q_r;
    rdata_s    = rdata_r;
    lane_s     = lane_r;
    settle_s   = settle_r;
    mux_dir_s  = mux_dir_r;
    line_oe_s  = 1'b0;
    line_val_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          rw_s      = rw;
          wdata_s   = wdata;
          mux_dir_s = rw;
          lane_s    = FIRST_LANE;
          settle_s  = {CNT_W{1'b0}};
          state_s   = TURN;
        end else begin
          state_s = IDLE;
        end
      end
      TURN: begin
        if (settle_r == SETTLE_LAST) begin
          state_s    = PRESENT;
          line_oe_s  = rw_r;
          line_val_s = wdata_r[lane_r];
        end else begin
          settle_s = settle_r + CNT_W'(1);
        end
      end
      PRESENT: begin
        state_s    = HOLD;
        line_oe_s  = line_oe_r;
        line_val_s = line_val_r;
      end
      HOLD: begin
        if (rw_r == DIR_GATHER) begin
          rdata_q_s[lane_r] = mux_line;
        end else begin
          rdata_q_s = rdata_q_r;
        end
        if (lane_r == LAST_LANE) begin
          state_s   = DONE;
          mux_dir_s = DIR_GATHER;
          if (rw_r == DIR_GATHER) begin
            rdata_s = rdata_q_s;
          end else begin
            rdata_s = rdata_r;
          end
        end else begin
`ifdef BIMUX_XFER_MSB_FIRST_EN
          lane_s = lane_r - SEL_W'(1);
`else
          lane_s = lane_r + SEL_W'(1);
`endif
          state_s    = PRESENT;
          line_oe_s  = rw_r;
          line_val_s = wdata_r[lane_s];
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s   = IDLE;
        mux_dir_s = DIR_GATHER;
      end
    endcase
    busy_s = (state_s != IDLE);
    done_s = (state_s == DONE);
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      rw_r       <= 1'b0;
      wdata_r    <= {LANES{1'b0}};
      rdata_q_r  <= {LANES{1'b0}};
      rdata_r    <= {LANES{1'b0}};
      lane_r     <= {SEL_W{1'b0}};
      settle_r   <= {CNT_W{1'b0}};
      mux_dir_r  <= DIR_GATHER;
      line_oe_r  <= 1'b0;
      line_val_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      rw_r       <= rw_s;
      wdata_r    <= wdata_s;
      rdata_q_r  <= rdata_q_s;
      rdata_r    <= rdata_s;
      lane_r     <= lane_s;
      settle_r   <= settle_s;
      mux_dir_r  <= mux_dir_s;
      line_oe_r  <= line_oe_s;
      line_val_r <= line_val_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  assign mux_line = line_oe_r ? line_val_r : 1'bz;
  assign busy     = busy_r;
  assign done     = done_r;
  assign rdata    = rdata_r;
  assign mux_dir  = mux_dir_r;
  assign mux_sel  = lane_r;

  bimux_xfer_ctrl_chk u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .line_oe (line_oe_r),
    .mux_dir (mux_dir_r)
  );

endmodule

// File: doc/bimux_xfer_ctrl.md
Name: bimux_xfer_ctrl

Overview:
- Sequencing initiator for one `bimux_8x1` in the subleq machine.
- Drives the mux `dir`/`sel` inputs and the mux's single-bit `out` line.
- Moves one byte per request:
  - write (scatter): a parallel byte is pushed lane by lane through the mux onto the 8 lane wires (`dir=1`);
  - read (gather): the 8 lane wires are collected lane by lane through the mux into a parallel byte (`dir=0`).
- Owns bus turnaround on the shared tri-state line so the controller and the mux never both drive it.

Parameters:
- LANES, 8, number of mux lanes; must equal 2**SEL_W.
- SEL_W, 3, width of mux_sel.
- SETTLE, 1, turnaround cycles (>=1) with line released after mux_dir changes, before the first lane.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- rw  in  1  0 = read/gather, 1 = write/scatter; captured with start.
- wdata  in  LANES  byte to scatter; captured with start.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle pulse; transfer complete.
- rdata  out  LANES  gathered byte; stable from done until the next accepted read.
- mux_dir  out  1  to bimux `dir`: 0 = lanes→line, 1 = line→lanes.
- mux_sel  out  SEL_W  to bimux `sel`.
- mux_line  inout  1  to bimux `out`; driven only while line_oe is high, else Z.

Behaviour:
- Reset, asynchronous, on rst_n low:
  - state=IDLE, busy=0, done=0, rdata=0;
  - mux_dir=0, mux_sel=0, line_oe=0 (line Z), lane counter 0.
- Reset asserted mid-transfer aborts the transfer at once. No done pulse; rdata is cleared.
- States are IDLE, TURN, PRESENT, HOLD, DONE.
- IDLE:
  - start=1 captures rw→rw_q and wdata→wdata_q; mux_dir<=rw; next state TURN.
  - start while not in IDLE is ignored; no queueing.
- TURN:
  - line_oe=0 for SETTLE cycles; mux_sel=first lane.
  - Then go to PRESENT.
- PRESENT (lane i):
  - mux_sel=i.
  - Write: line_oe=1, line=wdata_q[i].
  - Read: line_oe=0.
  - Next state HOLD.
- HOLD (lane i):
  - Outputs unchanged from PRESENT.
  - Read: rdata_q[i] <= mux_line at the clock edge that ends HOLD. X/Z is stored as is; no resolution.
  - If i is the last lane, go to DONE; otherwise advance i and go to PRESENT.
- DONE:
  - done=1 for one cycle; line_oe=0; mux_dir returns to 0.
  - rdata updates only on read transfers; a write leaves rdata untouched.
  - Next state IDLE.
- busy:
  - 0 in IDLE;
  - 1 in TURN/PRESENT/HOLD/DONE.
- Latency: start-accepted edge to done high = SETTLE + 2*LANES + 1 cycles (18 with defaults).
- Lane order is LSB first: lane 0..LANES-1 (see Optional Feature).
- Safe-default invariant: line_oe is never 1 while mux_dir=0; assertion required.
- start in the DONE cycle is ignored; it is accepted again from IDLE.

Optional Feature:
- Macro: BIMUX_XFER_MSB_FIRST_EN.
- Defined: lanes are walked LANES-1 down to 0. TURN presents mux_sel=LANES-1, and rdata bit mapping stays lane i → bit i.
- Undefined: LSB first, as above.
- Latency and all other timing are identical in both builds.

Decomposition:
- Shared package bimux_pkg holds:
  - state enum xfer_state_t {IDLE, TURN, PRESENT, HOLD, DONE};
  - constants DIR_GATHER=1'b0, DIR_SCATTER=1'b1;
  - LANES/SEL_W defaults.
- No sub-module; the lane counter and FSM are one always block pair.
- The tri-state driver is a single continuous assign in this module.

Test Plan:
- Reset with line Z, then release: all outputs 0; mux_dir=0; line Z for 5 idle cycles.
- Write 8'hA5 (rw=1, SETTLE=1):
  - mux_dir=1 one cycle after start;
  - line Z during TURN;
  - line sequence 1,0,1,0,0,1,0,1 on sel 0..7, each held 2 cycles;
  - done at cycle 18.
- Read with lane model driving 8'h3C through `bimux_8x1` (dir=0): rdata=8'h3C at done; line never driven by DUT.
- Read then write back-to-back: start asserted in the DONE cycle is ignored, reasserted in IDLE is accepted. After the write (8'hFF), rdata still equals the previous read value.
- rst_n low in HOLD of lane 4 during write 8'hFF: line Z and mux_dir=0 immediately (asynchronous); no done; rdata=0.
- BIMUX_XFER_MSB_FIRST_EN build, write 8'h01: sel sequence 7..0; line high only while sel=0, in the last lane slot.
